plreg_skid_lanes: RTL and testbench

- Parametrised pipeline register between two dual-/multi-issue stages, e.g. DE->EX or EX->WB.
- Replaces the fixed-width rst/stop pipeline registers with:
  - LANES parallel lanes moving as one group.
  - A valid/ready handshake with a 2-entry skid buffer, so in_ready is fully registered.
  - A whole-group flush.
  - A per-lane kill, used to squash only the younger lane on a taken branch.

---
 rtl/plreg_skid_lanes.sv | 105 ++++++++++
 tb/tb_plreg_skid_lanes.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/plreg_skid_lanes.sv
// Multi-lane pipeline register with a two-entry skid buffer, group flush and per-lane kill.
// MAIN drives the outputs; SKID absorbs the beat accepted while MAIN stalls, so in_ready is a flop output.
module plreg_skid_lanes #(
  parameter int LANES = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [LANES-1:0]       kill,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy
);

  logic [LANES-1:0]       main_valid, skid_valid;
  logic [LANES-1:0]       main_valid_nxt, skid_valid_nxt;
  logic [LANES*WIDTH-1:0] main_data, skid_data;
  logic [LANES*WIDTH-1:0] main_data_nxt, skid_data_nxt;
  logic                   main_occ, skid_occ, in_fire, out_fire;

  // Stored payload is always zero in invalid lanes, so the head data can drive out_data directly.
  function automatic logic [LANES*WIDTH-1:0] lane_mask(input logic [LANES-1:0] v,
                                                       input logic [LANES*WIDTH-1:0] d);
    logic [LANES*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (v[i]) r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign main_occ  = |main_valid;
  assign skid_occ  = |skid_valid;
  assign in_ready  = ~skid_occ;
  assign in_fire   = (|in_valid) & in_ready;
  assign out_fire  = main_occ & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_occ} + {1'b0, skid_occ};

  always_comb begin
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;

    if (!main_occ || out_fire) begin
      if (skid_occ) begin
        main_valid_nxt = skid_valid;
        main_data_nxt  = skid_data;
      end else if (in_fire) begin
        main_valid_nxt = in_valid;
        main_data_nxt  = lane_mask(in_valid, in_data);
      end else begin
        main_valid_nxt = '0;
        main_data_nxt  = '0;
      end
      skid_valid_nxt = '0;
      skid_data_nxt  = '0;
    end else if (in_fire) begin
      skid_valid_nxt = in_valid;
      skid_data_nxt  = lane_mask(in_valid, in_data);
    end

    main_valid_nxt = main_valid_nxt & ~kill;
    skid_valid_nxt = skid_valid_nxt & ~kill;
    main_data_nxt  = lane_mask(main_valid_nxt, main_data_nxt);
    skid_data_nxt  = lane_mask(skid_valid_nxt, skid_data_nxt);

    // A kill can empty the head while SKID survives; keep the head slot filled.
    if (!(|main_valid_nxt) && (|skid_valid_nxt)) begin
      main_valid_nxt = skid_valid_nxt;
      main_data_nxt  = skid_data_nxt;
      skid_valid_nxt = '0;
      skid_data_nxt  = '0;
    end

    if (flush) begin
      main_valid_nxt = '0;
      main_data_nxt  = '0;
      skid_valid_nxt = '0;
      skid_data_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= '0;
      main_data  <= '0;
      skid_valid <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      main_data  <= main_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
    end
  end

endmodule

// File: tb/tb_plreg_skid_lanes.sv
// Directed bench for plreg_skid_lanes with LANES=2, WIDTH=32.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_plreg_skid_lanes;

  localparam int LANES = 2;
  localparam int WIDTH = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic [LANES-1:0]       kill = '0;
  logic [LANES-1:0]       in_valid = '0;
  logic [LANES*WIDTH-1:0] in_data = '0;
  logic                   in_ready;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_ready = 1'b0;
  logic [1:0]             occupancy;

  int checks = 0;
  int errors = 0;

  plreg_skid_lanes #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .kill(kill),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] pk(input logic [31:0] l1, input logic [31:0] l0);
    return {l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [1:0] ev, input logic [63:0] ed,
                              input logic er, input logic [1:0] eo);
    checks++;
    if (out_valid !== ev) begin
      errors++; $display("[TB] FAIL %s out_valid: got %b want %b", tag, out_valid, ev);
    end
    checks++;
    if (out_data !== ed) begin
      errors++; $display("[TB] FAIL %s out_data: got %h want %h", tag, out_data, ed);
    end
    checks++;
    if (in_ready !== er) begin
      errors++; $display("[TB] FAIL %s in_ready: got %b want %b", tag, in_ready, er);
    end
    checks++;
    if (occupancy !== eo) begin
      errors++; $display("[TB] FAIL %s occupancy: got %0d want %0d", tag, occupancy, eo);
    end
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_data = '0; kill = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    expect_state("reset", 2'b00, 64'h0, 1'b1, 2'd0);
    step();
    step();
    rst = 1'b1;
    expect_state("reset_hold", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  task automatic test_stream();
    logic [31:0] l1, l0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      l1 = 32'h11 + 32'(k * 'h22);
      l0 = 32'h22 + 32'(k * 'h22);
      in_valid = 2'b11; in_data = pk(l1, l0);
      step();
      expect_state($sformatf("stream%0d", k), 2'b11, pk(l1, l0), 1'b1, 2'd1);
    end
    idle_inputs();
    step();
    expect_state("stream_drain", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 2'b11; in_data = pk(32'hA1, 32'hA0);
    step();
    expect_state("bp_A", 2'b11, pk(32'hA1, 32'hA0), 1'b1, 2'd1);
    in_data = pk(32'hB1, 32'hB0);
    step();
    expect_state("bp_B", 2'b11, pk(32'hA1, 32'hA0), 1'b0, 2'd2);
    in_data = pk(32'hC1, 32'hC0);
    step();
    expect_state("bp_C_held", 2'b11, pk(32'hA1, 32'hA0), 1'b0, 2'd2);
    out_ready = 1'b1;
    step();
    expect_state("bp_outB", 2'b11, pk(32'hB1, 32'hB0), 1'b1, 2'd1);
    step();
    expect_state("bp_outC", 2'b11, pk(32'hC1, 32'hC0), 1'b1, 2'd1);
    idle_inputs();
    step();
    expect_state("bp_drain", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  task automatic test_partial_kill();
    out_ready = 1'b0;
    in_valid = 2'b11; in_data = pk(32'h2, 32'h1);
    step();
    expect_state("pk_load", 2'b11, pk(32'h2, 32'h1), 1'b1, 2'd1);
    idle_inputs();
    kill = 2'b10;
    step();
    kill = 2'b00;
    expect_state("pk_killed", 2'b01, pk(32'h0, 32'h1), 1'b1, 2'd1);
    out_ready = 1'b1;
    step();
    expect_state("pk_drain", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  task automatic test_kill_compact();
    out_ready = 1'b0;
    in_valid = 2'b10; in_data = pk(32'hAA, 32'hBB);
    step();
    expect_state("kc_main", 2'b10, pk(32'hAA, 32'h0), 1'b1, 2'd1);
    in_valid = 2'b01; in_data = pk(32'hCC, 32'hDD);
    step();
    expect_state("kc_skid", 2'b10, pk(32'hAA, 32'h0), 1'b0, 2'd2);
    idle_inputs();
    kill = 2'b10;
    step();
    kill = 2'b00;
    expect_state("kc_compact", 2'b01, pk(32'h0, 32'hDD), 1'b1, 2'd1);
    out_ready = 1'b1;
    step();
    expect_state("kc_drain", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 2'b11; in_data = pk(32'hF1, 32'hF0);
    step();
    in_data = pk(32'hE1, 32'hE0);
    step();
    expect_state("fl_full", 2'b11, pk(32'hF1, 32'hF0), 1'b0, 2'd2);
    idle_inputs();
    out_ready = 1'b1;
    step();
    expect_state("fl_one", 2'b11, pk(32'hE1, 32'hE0), 1'b1, 2'd1);
    in_valid = 2'b11; in_data = pk(32'hD1, 32'hD0);
    flush = 1'b1;
    step();
    expect_state("fl_flush", 2'b00, 64'h0, 1'b1, 2'd0);
    idle_inputs();
    step();
    expect_state("fl_after", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 2'b11; in_data = pk(32'h91, 32'h90);
    step();
    in_data = pk(32'h81, 32'h80);
    step();
    idle_inputs();
    expect_state("ar_full", 2'b11, pk(32'h91, 32'h90), 1'b0, 2'd2);
    #3 rst = 1'b0;
    #1;
    expect_state("ar_async", 2'b00, 64'h0, 1'b1, 2'd0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 2'b11; in_data = pk(32'h71, 32'h70);
    step();
    expect_state("ar_first", 2'b11, pk(32'h71, 32'h70), 1'b1, 2'd1);
    idle_inputs();
    step();
    expect_state("ar_drain", 2'b00, 64'h0, 1'b1, 2'd0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_partial_kill();
    test_kill_compact();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
